// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register latency scoreboard, stall/bubble/flush control and operand forwarding
// Ports:
//   clk, reset                   core clock, asynchronous active-high reset
//   id_valid, id_rs1, id_rs2     decode instruction and its source registers
//   id_rs1_used, id_rs2_used     which sources are actually read
//   id_regwrite, id_dst, id_lat  destination write and its result latency
//   ex_redirect, pipe_hold       taken branch in execute / whole pipeline frozen
//   fwd_valid, fwd_dst, fwd_data forward sources, index 0 youngest
//   stall_if_id, bubble_ex, flush_if_id   pipeline controls
//   srca_mux/srca_forward, srcb_mux/srcb_forward   forwarded operands
//   stall_cnt                    saturating count of data-hazard stall cycles
module hazard_scoreboard #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int NFWD   = 3,
  parameter int MAXLAT = 8,
  parameter int CW     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [AW-1:0]        id_rs1,
  input  logic [AW-1:0]        id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic                 id_regwrite,
  input  logic [AW-1:0]        id_dst,
  input  logic [CW-1:0]        id_lat,
  input  logic                 ex_redirect,
  input  logic                 pipe_hold,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*AW-1:0]   fwd_dst,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  output logic                 stall_if_id,
  output logic                 bubble_ex,
  output logic                 flush_if_id,
  output logic                 srca_mux,
  output logic [XLEN-1:0]      srca_forward,
  output logic                 srcb_mux,
  output logic [XLEN-1:0]      srcb_forward,
  output logic [31:0]          stall_cnt
);
  logic [NREG-1:0] busy;
  logic            hz;
  logic            issue;
  logic            wr;
  logic [CW-1:0]   lat_c;
  // x0 has no counter and is never busy, so the hazard check needs no rs!=0 term
  assign busy[0] = 1'b0;
  assign hz = id_valid & ((id_rs1_used & busy[id_rs1]) | (id_rs2_used & busy[id_rs2]));
  assign issue = id_valid & ~pipe_hold & ~ex_redirect & ~hz;
  assign wr = issue & id_regwrite & (id_dst != '0);
  assign lat_c = (id_lat > CW'(MAXLAT)) ? CW'(MAXLAT) : id_lat;
  assign stall_if_id = pipe_hold | (~ex_redirect & hz);
  assign bubble_ex = ~pipe_hold & (ex_redirect | hz);
  assign flush_if_id = ~pipe_hold & ex_redirect;
  for (genvar r = 1; r < NREG; r++) begin : g_reg
    logic [CW-1:0] c;
    // a new write to the same register replaces the countdown (youngest latency wins)
    always_ff @(posedge clk or posedge reset)
      if (reset) c <= '0;
      else if (!pipe_hold) c <= (wr && id_dst == AW'(r)) ? lat_c : ((c != '0) ? c - 1'b1 : c);
    assign busy[r] = |c;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) stall_cnt <= '0;
    else if (!pipe_hold && !ex_redirect && hz && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  // scan oldest to youngest so the lowest matching index is the one left standing
  always_comb begin
    srca_mux = 1'b0;
    srca_forward = '0;
    srcb_mux = 1'b0;
    srcb_forward = '0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (id_rs1_used && id_rs1 != '0 && fwd_valid[i] && fwd_dst[i*AW +: AW] == id_rs1) begin
        srca_mux = 1'b1;
        srca_forward = fwd_data[i*XLEN +: XLEN];
      end
      if (id_rs2_used && id_rs2 != '0 && fwd_valid[i] && fwd_dst[i*AW +: AW] == id_rs2) begin
        srcb_mux = 1'b1;
        srcb_forward = fwd_data[i*XLEN +: XLEN];
      end
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: randomized and directed checks of hazard_scoreboard against a ready-time model
module tb_hazard_scoreboard;
  localparam int XLEN = 64;
  localparam int AW = 5;
  localparam int NFWD = 3;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_rs1_used, id_rs2_used, id_regwrite, ex_redirect, pipe_hold;
  logic [AW-1:0] id_rs1, id_rs2, id_dst;
  logic [CW-1:0] id_lat;
  logic [NFWD-1:0] fwd_valid;
  logic [NFWD*AW-1:0] fwd_dst;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic stall_if_id, bubble_ex, flush_if_id, srca_mux, srcb_mux;
  logic [XLEN-1:0] srca_forward, srcb_forward;
  logic [31:0] stall_cnt;
  int checks = 0;
  int errors = 0;
  // model: t counts non-frozen cycles; a register is busy while t < ready_at
  int t;
  int ready_at [32];
  logic [31:0] stalls;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_regwrite(id_regwrite),
    .id_dst(id_dst), .id_lat(id_lat), .ex_redirect(ex_redirect), .pipe_hold(pipe_hold),
    .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
    .stall_if_id(stall_if_id), .bubble_ex(bubble_ex), .flush_if_id(flush_if_id),
    .srca_mux(srca_mux), .srca_forward(srca_forward), .srcb_mux(srcb_mux),
    .srcb_forward(srcb_forward), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit busy(input logic [AW-1:0] r);
    return r != 0 && ready_at[r] > t;
  endfunction

  task automatic fwd_ref(input logic used, input logic [AW-1:0] rs, output logic m, output logic [XLEN-1:0] d);
    m = 1'b0;
    d = '0;
    if (used && rs != 0)
      for (int i = 0; i < NFWD; i++)
        if (!m && fwd_valid[i] && fwd_dst[i*AW +: AW] == rs) begin
          m = 1'b1;
          d = fwd_data[i*XLEN +: XLEN];
        end
  endtask

  task automatic model_reset();
    t = 0;
    stalls = '0;
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] r1, input logic u1, input logic [AW-1:0] r2,
                        input logic u2, input logic w, input logic [AW-1:0] d, input logic [CW-1:0] l);
    id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    id_regwrite = w; id_dst = d; id_lat = l;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    ex_redirect = 0; pipe_hold = 0; fwd_valid = '0; fwd_dst = '0; fwd_data = '0;
  endtask

  task automatic step(input string tag);
    logic hz, am, bm;
    logic [XLEN-1:0] ad, bd;
    int l;
    #1;
    hz = id_valid && ((id_rs1_used && busy(id_rs1)) || (id_rs2_used && busy(id_rs2)));
    fwd_ref(id_rs1_used, id_rs1, am, ad);
    fwd_ref(id_rs2_used, id_rs2, bm, bd);
    check({tag, ".stall"}, 64'(stall_if_id), 64'(pipe_hold || (!ex_redirect && hz)));
    check({tag, ".bubble"}, 64'(bubble_ex), 64'(!pipe_hold && (ex_redirect || hz)));
    check({tag, ".flush"}, 64'(flush_if_id), 64'(!pipe_hold && ex_redirect));
    check({tag, ".amux"}, 64'(srca_mux), 64'(am));
    check({tag, ".afwd"}, srca_forward, ad);
    check({tag, ".bmux"}, 64'(srcb_mux), 64'(bm));
    check({tag, ".bfwd"}, srcb_forward, bd);
    check({tag, ".scnt"}, 64'(stall_cnt), 64'(stalls));
    if (!pipe_hold) begin
      if (!ex_redirect && hz && stalls != 32'hFFFF_FFFF) stalls++;
      if (id_valid && !ex_redirect && !hz && id_regwrite && id_dst != 0) begin
        l = (id_lat > 8) ? 8 : int'(id_lat);
        ready_at[id_dst] = t + 1 + l;
      end
      t++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    model_reset();
    reset = 1'b1;
    #3;
    check("rst.stall", 64'(stall_if_id), 0);
    check("rst.bubble", 64'(bubble_ex), 0);
    check("rst.flush", 64'(flush_if_id), 0);
    check("rst.scnt", 64'(stall_cnt), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step("idle");
    // load-use: one stall cycle then issue
    set_id(1, 0, 0, 0, 0, 1, 5, 1);
    step("ld5");
    set_id(1, 5, 1, 0, 0, 1, 6, 0);
    step("use5_stall");
    step("use5_issue");
    check("ld_use.scnt", 64'(stall_cnt), 1);
    // ALU result forwarded next cycle without stall
    set_id(1, 0, 0, 0, 0, 1, 3, 0);
    step("alu3");
    set_id(1, 3, 1, 0, 0, 0, 0, 0);
    fwd_valid = 3'b001; fwd_dst[0 +: AW] = 3; fwd_data[0 +: XLEN] = 64'h55;
    step("fwd3");
    check("fwd3.a", srca_forward, 64'h55);
    // priority: youngest of two matching sources; x0 never forwarded
    set_id(1, 0, 1, 7, 1, 0, 0, 0);
    fwd_valid = 3'b111;
    fwd_dst = {5'd7, 5'd0, 5'd7};
    fwd_data = {64'hB, 64'h77, 64'hA};
    step("prio");
    check("prio.b", srcb_forward, 64'hA);
    check("prio.x0", 64'(srca_mux), 0);
    idle();
    // long div, redirect collides with hazard
    set_id(1, 0, 0, 0, 0, 1, 9, 8);
    step("div9");
    set_id(1, 9, 1, 0, 0, 0, 0, 0);
    ex_redirect = 1;
    step("redir");
    ex_redirect = 0;
    for (int i = 0; i < 9; i++) step("div_wait");
    // freeze during a pending latency
    set_id(1, 0, 0, 0, 0, 1, 4, 2);
    step("w4");
    set_id(1, 0, 0, 4, 1, 0, 0, 0);
    pipe_hold = 1;
    ex_redirect = 1;
    for (int i = 0; i < 3; i++) step("hold");
    pipe_hold = 0;
    ex_redirect = 0;
    for (int i = 0; i < 3; i++) step("post_hold");
    // latency clamp
    set_id(1, 0, 0, 0, 0, 1, 10, 15);
    step("lat15");
    set_id(1, 10, 1, 10, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("clamp_wait");
    // reset in the middle of a stall
    set_id(1, 0, 0, 0, 0, 1, 11, 8);
    step("w11");
    set_id(1, 11, 1, 0, 0, 0, 0, 0);
    step("stall11");
    reset = 1'b1;
    #1;
    check("midrst.stall", 64'(stall_if_id), 0);
    check("midrst.bubble", 64'(bubble_ex), 0);
    check("midrst.scnt", 64'(stall_cnt), 0);
    model_reset();
    idle();
    @(negedge clk);
    reset = 1'b0;
    step("post_rst");
    // random traffic on a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      set_id($urandom_range(3) != 0, AW'($urandom_range(7)), 1'($urandom), AW'($urandom_range(7)),
             1'($urandom), 1'($urandom), AW'($urandom_range(7)), CW'($urandom_range(15)));
      pipe_hold = ($urandom_range(7) == 0);
      ex_redirect = ($urandom_range(7) == 0);
      fwd_valid = NFWD'($urandom);
      for (int i = 0; i < NFWD; i++) begin
        fwd_dst[i*AW +: AW] = AW'($urandom_range(7));
        fwd_data[i*XLEN +: XLEN] = {$urandom, $urandom};
      end
      step("rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
